// File: rtl/sec_key_seq.sv
// Bus-mapped security key sequencer. An LFSR advances on each qualified read and
// checks the address-supplied key. A run of correct keys unlocks the block, and repeated misses latch a fault.
module sec_key_seq #(
    parameter int unsigned        STATE_W  = 6,
    parameter logic [STATE_W-1:0] TAPS     = 6'h30,
    parameter logic [STATE_W-1:0] INIT     = 6'h01,
    parameter int unsigned        KEY_W    = 4,
    parameter logic [KEY_W-1:0]   KEY_MASK = '0,
    parameter int unsigned        OUT_W    = 2,
    parameter int unsigned        SEQ_LEN  = 4,
    parameter int unsigned        MAX_FAIL = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sel,
    input  logic               rd,
    input  logic [KEY_W-1:0]   key,
    output logic [OUT_W-1:0]   dout,
    output logic               dout_vld,
    output logic [STATE_W-1:0] state,
    output logic               unlocked,
    output logic               fault
);

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        UNLOCKED = 2'd1,
        FAULT    = 2'd2
    } fsm_e;

    fsm_e               fsm_q, fsm_d;
    logic [STATE_W-1:0] state_q, state_d;
    logic [3:0]         match_cnt_q, match_cnt_d;
    logic [3:0]         fail_cnt_q, fail_cnt_d;
    logic [OUT_W-1:0]   dout_q, dout_d;
    logic               dout_vld_q, dout_vld_d;
    logic               unlocked_q, unlocked_d;
    logic               fault_q, fault_d;

    logic               rd_acc;
    logic               wr_acc;
    logic               fb;
    logic [STATE_W-1:0] state_adv;
    logic [KEY_W-1:0]   exp_key;
    logic [OUT_W-1:0]   rb_locked;
    logic [OUT_W-1:0]   rb_open;
    logic [3:0]         match_inc;
    logic [3:0]         fail_inc;

    assign rd_acc = sel & rd;
    assign wr_acc = sel & ~rd;

    // Every value below is derived from the pre-advance state.
    assign fb        = ^(state_q & TAPS);
    assign state_adv = {state_q[STATE_W-2:0], fb};
    assign exp_key   = state_q[KEY_W-1:0] ^ KEY_MASK;
    assign rb_open   = state_q[OUT_W-1:0];
    assign rb_locked = state_q[STATE_W-1 -: OUT_W] ^ state_q[OUT_W-1:0];
    assign match_inc = match_cnt_q + 4'd1;
    assign fail_inc  = fail_cnt_q + 4'd1;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        fsm_d       = fsm_q;
        state_d     = state_q;
        match_cnt_d = match_cnt_q;
        fail_cnt_d  = fail_cnt_q;
        dout_d      = dout_q;
        dout_vld_d  = rd_acc;

        unique case (fsm_q)
            LOCKED: begin
                if (rd_acc) begin
                    state_d = state_adv;
                    dout_d  = rb_locked;
                    if (key == exp_key) begin
                        fail_cnt_d = 4'd0;
                        if (match_inc == 4'(SEQ_LEN)) begin
                            fsm_d       = UNLOCKED;
                            match_cnt_d = 4'd0;
                        end else begin
                            match_cnt_d = match_inc;
                        end
                    end else begin
                        match_cnt_d = 4'd0;
                        fail_cnt_d  = fail_inc;
                        if (fail_inc == 4'(MAX_FAIL)) begin
                            fsm_d = FAULT;
                        end
                    end
                end else if (wr_acc) begin
                    match_cnt_d = 4'd0;
                    fail_cnt_d  = 4'd0;
                end
            end
            UNLOCKED: begin
                if (rd_acc) begin
                    state_d = state_adv;
                    dout_d  = rb_open;
                end else if (wr_acc) begin
                    fsm_d       = LOCKED;
                    match_cnt_d = 4'd0;
                    fail_cnt_d  = 4'd0;
                end
            end
            FAULT: begin
                // Frozen until reset; writes are ignored, but reads still strobe a zero.
                if (rd_acc) begin
                    dout_d = '0;
                end
            end
            default: begin
                fsm_d = LOCKED;
            end
        endcase

        unlocked_d = (fsm_d == UNLOCKED);
        fault_d    = (fsm_d == FAULT);
    end

    always_ff @(posedge clk) begin
        // NOTE: registers are updated only with non-blocking assignments so all of them see the same pre-edge values.
        if (rst) begin
            fsm_q       <= LOCKED;
            state_q     <= INIT;
            match_cnt_q <= 4'd0;
            fail_cnt_q  <= 4'd0;
            dout_q      <= '0;
            dout_vld_q  <= 1'b0;
            unlocked_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            state_q     <= state_d;
            match_cnt_q <= match_cnt_d;
            fail_cnt_q  <= fail_cnt_d;
            dout_q      <= dout_d;
            dout_vld_q  <= dout_vld_d;
            unlocked_q  <= unlocked_d;
            fault_q     <= fault_d;
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;
    assign state    = state_q;
    assign unlocked = unlocked_q;
    assign fault    = fault_q;

endmodule

// File: tb/tb_sec_key_seq.sv
// Bench for sec_key_seq with two configurations sharing one stimulus stream. A behavioural
// model checks them every cycle, and literal expectations pin the directed scenarios.
module tb_sec_key_seq;

    localparam int M_LOCK  = 0;
    localparam int M_OPEN  = 1;
    localparam int M_FAULT = 2;

    logic       clk;
    logic       rst;
    logic       sel;
    logic       rd;
    logic [3:0] key;

    logic [1:0] dout0;
    logic       vld0;
    logic [5:0] state0;
    logic       unl0;
    logic       flt0;
    logic [3:0] dout1;
    logic       vld1;
    logic [7:0] state1;
    logic       unl1;
    logic       flt1;

    int n_vec  = 0;
    int n_err  = 0;
    bit armed  = 0;

    typedef struct {
        int st;
        int mode;
        int mc;
        int fc;
        int dout;
        int vld;
    } mdl_t;

    mdl_t m [2];
    int   p_w     [2] = '{6, 8};
    int   p_taps  [2] = '{'h30, 'hB8};
    int   p_kmask [2] = '{0, 'hA};
    int   p_ow    [2] = '{2, 4};

    sec_key_seq u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .rd       (rd),
        .key      (key),
        .dout     (dout0),
        .dout_vld (vld0),
        .state    (state0),
        .unlocked (unl0),
        .fault    (flt0)
    );

    sec_key_seq #(
        .STATE_W  (8),
        .TAPS     (8'hB8),
        .INIT     (8'h01),
        .KEY_W    (4),
        .KEY_MASK (4'hA),
        .OUT_W    (4),
        .SEQ_LEN  (4),
        .MAX_FAIL (3)
    ) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .sel      (sel),
        .rd       (rd),
        .key      (key),
        .dout     (dout1),
        .dout_vld (vld1),
        .state    (state1),
        .unlocked (unl1),
        .fault    (flt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference behaviour: integer arithmetic on the state value, one call per clock edge.
    function automatic mdl_t model_step(input mdl_t mi, input int i, input logic r,
                                        input logic s, input logic rdx, input int k);
        mdl_t mo;
        int   pre;
        int   omask;
        mo = mi;
        if (r) begin
            mo.st = 1; mo.mode = M_LOCK; mo.mc = 0; mo.fc = 0; mo.dout = 0; mo.vld = 0;
            return mo;
        end
        mo.vld = (s && rdx) ? 1 : 0;
        if (s && rdx) begin
            pre   = mi.st;
            omask = (1 << p_ow[i]) - 1;
            if (mi.mode == M_FAULT)     mo.dout = 0;
            else if (mi.mode == M_OPEN) mo.dout = pre & omask;
            else                        mo.dout = ((pre >> (p_w[i] - p_ow[i])) ^ pre) & omask;
            if (mi.mode != M_FAULT)
                mo.st = ((pre * 2) + ($countones(pre & p_taps[i]) % 2)) % (1 << p_w[i]);
            if (mi.mode == M_LOCK) begin
                if (k == ((pre % 16) ^ p_kmask[i])) begin
                    mo.mc = mi.mc + 1;
                    mo.fc = 0;
                    if (mo.mc == 4) begin
                        mo.mode = M_OPEN;
                        mo.mc   = 0;
                    end
                end else begin
                    mo.mc = 0;
                    mo.fc = mi.fc + 1;
                    if (mo.fc == 3) mo.mode = M_FAULT;
                end
            end
        end else if (s && !rdx && mi.mode != M_FAULT) begin
            mo.mode = M_LOCK; mo.mc = 0; mo.fc = 0;
        end
        return mo;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) m[i] = model_step(m[i], i, rst, sel, rd, int'(key));
    end

    // dout is compared whenever it is meaningful: on a strobe, or while not faulted.
    always @(negedge clk) begin
        if (armed) begin
            check("m0.state", 32'(state0), m[0].st);
            check("m0.vld",   32'(vld0),   m[0].vld);
            check("m0.unl",   32'(unl0),   (m[0].mode == M_OPEN)  ? 1 : 0);
            check("m0.fault", 32'(flt0),   (m[0].mode == M_FAULT) ? 1 : 0);
            if (m[0].vld == 1 || m[0].mode != M_FAULT) check("m0.dout", 32'(dout0), m[0].dout);
            check("m1.state", 32'(state1), m[1].st);
            check("m1.vld",   32'(vld1),   m[1].vld);
            check("m1.unl",   32'(unl1),   (m[1].mode == M_OPEN)  ? 1 : 0);
            check("m1.fault", 32'(flt1),   (m[1].mode == M_FAULT) ? 1 : 0);
            if (m[1].vld == 1 || m[1].mode != M_FAULT) check("m1.dout", 32'(dout1), m[1].dout);
        end
    end

    // Called at a falling edge; returns at the next one, with the access's results visible.
    task automatic access(input logic r, input logic [3:0] k);
        sel = 1'b1; rd = r; key = k;
        @(negedge clk);
        sel = 1'b0; rd = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] k, input int exp_dout, input int exp_state, input string tag);
        access(1'b1, k);
        check({tag, ".dout"},  32'(dout0),  exp_dout);
        check({tag, ".state"}, 32'(state0), exp_state);
        check({tag, ".vld"},   32'(vld0),   1);
    endtask

    initial begin
        logic [3:0] unlock_keys [4];
        logic [3:0] recov_keys  [7];
        int         choice;
        unlock_keys = '{4'h1, 4'h2, 4'h4, 4'h8};
        recov_keys  = '{4'h1, 4'h2, 4'hF, 4'h8, 4'h0, 4'h1, 4'h3};
        rst = 1'b1; sel = 1'b0; rd = 1'b0; key = 4'h0;
        @(negedge clk);
        rst = 1'b0;
        armed = 1'b1;

        // Reset state, then idle.
        check("rst.state", 32'(state0), 32'h01);
        check("rst.dout",  32'(dout0),  0);
        check("rst.vld",   32'(vld0),   0);
        check("rst.unl",   32'(unl0),   0);
        check("rst.fault", 32'(flt0),   0);
        repeat (10) @(negedge clk);
        check("idle.state", 32'(state0), 32'h01);
        check("idle.unl",   32'(unl0),   0);

        // Unlock with 1,2,4,8.
        rd_chk(4'h1, 'b01, 'h02, "ul1");
        rd_chk(4'h2, 'b10, 'h04, "ul2");
        check("ul2.unl", 32'(unl0), 0);
        rd_chk(4'h4, 'b00, 'h08, "ul3");
        rd_chk(4'h8, 'b00, 'h10, "ul4");
        check("ul4.unl", 32'(unl0), 1);
        rd_chk(4'h0, 'b00, 'h21, "ul5");
        rd_chk(4'h5, 'b01, 'h03, "ul6");

        // Fault after three misses.
        do_reset();
        for (int i = 0; i < 3; i++) access(1'b1, 4'hF);
        check("flt.fault", 32'(flt0),   1);
        check("flt.state", 32'(state0), 'h08);
        rd_chk(4'h8, 0, 'h08, "flt4");
        access(1'b0, 4'h0);
        check("flt.wr.fault", 32'(flt0), 1);
        check("flt.wr.vld",   32'(vld0), 0);
        do_reset();
        check("flt.rst.fault", 32'(flt0), 0);

        // Relock by write, then re-unlock from the current state.
        for (int i = 0; i < 4; i++) access(1'b1, unlock_keys[i]);
        check("rl.unl", 32'(unl0), 1);
        access(1'b0, 4'h0);
        check("rl.wr.unl",   32'(unl0),   0);
        check("rl.wr.state", 32'(state0), 'h10);
        check("rl.wr.vld",   32'(vld0),   0);
        access(1'b1, 4'h0);
        access(1'b1, 4'h1);
        access(1'b1, 4'h3);
        check("rl.3.unl", 32'(unl0), 0);
        access(1'b1, 4'h6);
        check("rl.4.unl", 32'(unl0), 1);

        // Mismatch recovery.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            access(1'b1, recov_keys[i]);
            check("mr.fault", 32'(flt0), 0);
            check("mr.unl",   32'(unl0), (i == 6) ? 1 : 0);
        end

        // Reset colliding with a read mid-sequence.
        do_reset();
        access(1'b1, 4'h1);
        access(1'b1, 4'h2);
        rst = 1'b1; sel = 1'b1; rd = 1'b1; key = 4'h4;
        @(negedge clk);
        rst = 1'b0; sel = 1'b0; rd = 1'b0;
        check("rc.state", 32'(state0), 'h01);
        check("rc.vld",   32'(vld0),   0);
        check("rc.dout",  32'(dout0),  0);
        for (int i = 0; i < 3; i++) access(1'b1, unlock_keys[i]);
        check("rc.3.unl", 32'(unl0), 0);
        access(1'b1, unlock_keys[3]);
        check("rc.4.unl", 32'(unl0), 1);

        // Wide configuration: keys B,8,E,2 through states 01,02,04,08.
        do_reset();
        access(1'b1, 4'hB); check("w1.dout", 32'(dout1), 'h1); check("w1.state", 32'(state1), 'h02);
        access(1'b1, 4'h8); check("w2.dout", 32'(dout1), 'h2); check("w2.state", 32'(state1), 'h04);
        access(1'b1, 4'hE); check("w3.dout", 32'(dout1), 'h4); check("w3.state", 32'(state1), 'h08);
        access(1'b1, 4'h2); check("w4.dout", 32'(dout1), 'h8); check("w4.state", 32'(state1), 'h11);
        check("w4.unl", 32'(unl1), 1);
        access(1'b1, 4'h0); check("w5.dout", 32'(dout1), 'h1); check("w5.state", 32'(state1), 'h23);

        // Randomised traffic, keys biased toward the correct value for either instance.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            choice = int'($urandom_range(0, 3));
            rst = ($urandom_range(0, 39) == 0);
            sel = ($urandom_range(0, 3) != 0);
            rd  = ($urandom_range(0, 7) != 0);
            if (choice <= 1)      key = 4'(m[0].st % 16);
            else if (choice == 2) key = 4'((m[1].st % 16) ^ p_kmask[1]);
            else                  key = 4'($urandom_range(0, 15));
            @(negedge clk);
        end
        rst = 1'b0; sel = 1'b0; rd = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sec_key_seq.md
# sec_key_seq

Parametrised bus-mapped security key sequencer. It is the next generation of the six-bit GAL key state machines, with configurable state, key and readback widths and an explicit unlock/fault FSM. Each qualified read access to the key window advances an LFSR state register and checks the address-supplied key against the current state. The block returns a scrambled readback while locked, returns plain state bits once the challenge sequence completes, and latches a sticky fault after repeated failures.

## Interface
Parameters:
- STATE_W, 6: LFSR width, 4..16.
- TAPS, 6'h30: feedback tap mask (STATE_W bits).
- INIT, 6'h01: state reset value; nonzero.
- KEY_W, 4: key bits taken from the address bus, ≤ STATE_W.
- KEY_MASK, 0: XOR mask applied to the expected key (KEY_W bits).
- OUT_W, 2: readback width, ≤ STATE_W/2.
- SEQ_LEN, 4: consecutive correct keys required to unlock, 1..15.
- MAX_FAIL, 3: consecutive wrong keys that trigger a fault, 1..15.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-high.
- sel  in  1  window decode (chip select ∧ address window), one cycle per access.
- rd  in  1  1 = read access, 0 = write access; sampled when sel=1.
- key  in  KEY_W  key bits from the address bus.
- dout  out  OUT_W  registered readback data.
- dout_vld  out  1  one-cycle strobe: dout is valid for the last read.
- state  out  STATE_W  current LFSR state (debug).
- unlocked  out  1  sequence complete.
- fault  out  1  sticky lockout.

## Operation
- Access decoding: rd_acc = sel ∧ rd; wr_acc = sel ∧ ¬rd.
- LFSR step: fb = ^(state & TAPS); next = {state[STATE_W-2:0], fb}.
- Expected key: exp = state[KEY_W-1:0] ^ KEY_MASK, taken from the pre-advance state.
- Readback function:
  - Unlocked: state[OUT_W-1:0].
  - Locked: state[STATE_W-1 -: OUT_W] ^ state[OUT_W-1:0].
  - Fault: all zeros.
  - Always computed from the pre-advance state.
- FSM states are LOCKED, UNLOCKED and FAULT. Counters match_cnt and fail_cnt are each 4 bits.
- LOCKED, on rd_acc:
  - state advances and dout is loaded.
  - If key == exp: match_cnt++ and fail_cnt is cleared. When match_cnt reaches SEQ_LEN, go to UNLOCKED and clear match_cnt.
  - Otherwise: match_cnt is cleared and fail_cnt++. When fail_cnt reaches MAX_FAIL, go to FAULT.
- UNLOCKED, on rd_acc: state advances and dout is loaded. The key is ignored.
- FAULT: state is frozen and dout is forced to 0. dout_vld still pulses for each rd_acc. Only rst exits FAULT.
- wr_acc in LOCKED or UNLOCKED (relock):
  - Go to LOCKED and clear both counters.
  - state is unchanged and there is no dout_vld.
- wr_acc in FAULT: ignored.
- Outputs: unlocked = (FSM == UNLOCKED); fault = (FSM == FAULT).

## Timing
- Reset values: state = INIT, FSM = LOCKED, counters = 0, dout = 0, dout_vld = 0, unlocked = 0, fault = 0.
- Read latency is 1 cycle. The rising edge that samples rd_acc updates state, dout, the counters and the FSM together. dout_vld is high for exactly the following cycle.
- Back-to-back accesses (sel held high) are legal. One step is taken per cycle.
- unlocked/fault assert in the cycle after the completing access.
- rst in the same cycle as sel: reset wins and the access is dropped.
- rst mid-sequence discards partial match/fail counts.
- The state never reaches 0 for a primitive TAPS. The block does not guard against a non-primitive TAPS; that is the integrator's responsibility.

## Test plan
- Reset then idle: state = 0x01, dout = 0, all flags = 0, with no change over 10 idle cycles.
- Unlock: reads with key = 1, 2, 4, 8.
  - state goes 0x01→0x02→0x04→0x08→0x10.
  - Locked dout values are 01, 10, 00, 00.
  - unlocked = 1 after the 4th read.
  - The next read returns dout = 00 with state → 0x21; the read after that returns 01.
- Fault: three reads with key = 0xF from reset.
  - fail_cnt reaches 3 and fault = 1.
  - A further read gives dout = 0 with dout_vld = 1, and state stays at 0x08.
  - A write does not clear fault; rst does.
- Relock: unlock, then a write access.
  - unlocked drops next cycle and state is unchanged.
  - A subsequent correct 4-key sequence, taken from the current state, unlocks again.
- Mismatch recovery: keys 1, 2, 0xF, then the correct keys for states 0x08, 0x10, 0x21, 0x03.
  - The third read clears the match count; the block unlocks only after the final four correct reads.
  - fail_cnt is cleared by the first correct key after the mismatch, so fault stays 0.
- Reset collision and parameters:
  - rst with sel=rd=1 mid-sequence: the access is dropped and state = INIT.
  - Repeat the unlock test with STATE_W=8, TAPS=8'hB8, KEY_W=4, OUT_W=4, KEY_MASK=4'hA.
